// File: rtl/fp_align_stage.sv
// fp_align_stage: FP32 adder front end.
// Unpacks two IEEE-754 single operands, compares their magnitudes and
// right-aligns the smaller mantissa (with sticky) into the MW-bit
// {hidden, frac[22:0], guard/round/sticky} format. The stage is a two-deep
// valid/ready pipeline. It sustains one result per cycle and is safe under
// backpressure.
module fp_align_stage #(
  parameter int MW = 28
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  input  logic          in_as,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          SA,
  output logic          SB,
  output logic          A_S,
  output logic          Comp,
  output logic [MW-1:0] A,
  output logic [MW-1:0] B,
  output logic [7:0]    ES,
  output logic          out_nan,
  output logic          out_inf
);

  // The shift amount needs to hold every value from 0 to MW.
  localparam int SHW = $clog2(MW + 1);
  localparam logic [7:0]     MW_E  = 8'(MW);
  localparam logic [SHW-1:0] MW_SH = SHW'(MW);

  // ---------------------------------------------------------------------------
  // Handshake: each stage advances when its successor is empty or draining
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s1_en;
  logic s2_en;

  assign s2_en    = ~out_valid | out_ready;
  assign s1_en    = ~s1_valid | s2_en;
  assign in_ready = s1_en;

  // ---------------------------------------------------------------------------
  // Stage 1 decode (combinational from the operand inputs)
  // ---------------------------------------------------------------------------
  logic [7:0]     ea_raw, eb_raw, ea, eb, d, es_c;
  logic [22:0]    fa, fb;
  logic [MW-1:0]  ma, mb;
  logic           a_nan, b_nan, a_inf, b_inf, eff_sub, nan_c, inf_c, comp_c;
  logic [SHW-1:0] sh_c;

  assign ea_raw = in_a[30:23];
  assign eb_raw = in_b[30:23];
  assign fa     = in_a[22:0];
  assign fb     = in_b[22:0];

  // A denormal operand uses exponent 1 and has no hidden bit.
  assign ea = (ea_raw == 8'd0) ? 8'd1 : ea_raw;
  assign eb = (eb_raw == 8'd0) ? 8'd1 : eb_raw;
  assign ma = {(ea_raw != 8'd0), fa, {(MW-24){1'b0}}};
  assign mb = {(eb_raw != 8'd0), fb, {(MW-24){1'b0}}};

  // Exact magnitudes compare as {exponent, mantissa}. A tie counts as A >= B.
  assign comp_c = ({ea, ma} >= {eb, mb});
  assign d      = (ea >= eb) ? (ea - eb) : (eb - ea);
  assign es_c   = (ea >= eb) ? ea : eb;
  assign sh_c   = (d >= MW_E) ? MW_SH : d[SHW-1:0];

  assign a_nan   = (&ea_raw) &  (|fa);
  assign b_nan   = (&eb_raw) &  (|fb);
  assign a_inf   = (&ea_raw) & ~(|fa);
  assign b_inf   = (&eb_raw) & ~(|fb);
  assign eff_sub = in_a[31] ^ in_b[31] ^ in_as;
  assign nan_c   = a_nan | b_nan | (a_inf & b_inf & eff_sub);
  assign inf_c   = (a_inf | b_inf) & ~nan_c;

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic           s1_sa, s1_sb, s1_as, s1_comp, s1_nan, s1_inf;
  logic [MW-1:0]  s1_ma, s1_mb;
  logic [7:0]     s1_es;
  logic [SHW-1:0] s1_sh;

  // Capture the decoded operand pair whenever stage 1 can advance.
  // NOTE: registers use non-blocking assignment so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sa    <= 1'b0;
      s1_sb    <= 1'b0;
      s1_as    <= 1'b0;
      s1_comp  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_ma    <= '0;
      s1_mb    <= '0;
      s1_es    <= '0;
      s1_sh    <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      s1_sa    <= in_a[31];
      s1_sb    <= in_b[31];
      s1_as    <= in_as;
      s1_comp  <= comp_c;
      s1_nan   <= nan_c;
      s1_inf   <= inf_c;
      s1_ma    <= ma;
      s1_mb    <= mb;
      s1_es    <= es_c;
      s1_sh    <= sh_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: align the smaller mantissa
  // ---------------------------------------------------------------------------
  // Right-shift by sh. Every bit shifted out is ORed into bit 0 as sticky.
  // A full-width shift leaves only the sticky bit.
  function automatic logic [MW-1:0] shr_sticky(input logic [MW-1:0] m,
                                               input logic [SHW-1:0] sh);
    logic [MW-1:0] mask;
    logic [MW-1:0] q;
    if (sh >= MW_SH) begin
      q = {{(MW-1){1'b0}}, |m};
    end else begin
      mask = ~({MW{1'b1}} << sh);
      q    = m >> sh;
      q[0] = q[0] | (|(m & mask));
    end
    return q;
  endfunction

  logic [MW-1:0] a_al, b_al;

  // Only the operand that is smaller in magnitude is shifted. Operand positions are kept.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    a_al = s1_ma;
    b_al = s1_mb;
    if (s1_comp) b_al = shr_sticky(s1_mb, s1_sh);
    else         a_al = shr_sticky(s1_ma, s1_sh);
  end

  // Output register. It holds its contents while the downstream stage stalls.
  // NOTE: the datapath flops are reset too, so the outputs read as zero straight after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      SA        <= 1'b0;
      SB        <= 1'b0;
      A_S       <= 1'b0;
      Comp      <= 1'b0;
      A         <= '0;
      B         <= '0;
      ES        <= '0;
      out_nan   <= 1'b0;
      out_inf   <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      SA        <= s1_sa;
      SB        <= s1_sb;
      A_S       <= s1_as;
      Comp      <= s1_comp;
      A         <= a_al;
      B         <= b_al;
      ES        <= s1_es;
      out_nan   <= s1_nan;
      out_inf   <= s1_inf;
    end
  end

endmodule

// File: tb/tb_fp_align_stage.sv
// tb_fp_align_stage: scoreboard bench for fp_align_stage.
// The driver pushes the hand-computed expected result when a pair is accepted.
// The monitor pops and compares the entry when a result leaves the stage.
module tb_fp_align_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_as;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic        SA, SB, A_S, Comp, out_nan, out_inf;
  logic [27:0] A, B;
  logic [7:0]  ES;

  fp_align_stage #(.MW(28)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_as(in_as),
    .out_valid(out_valid), .out_ready(out_ready),
    .SA(SA), .SB(SB), .A_S(A_S), .Comp(Comp),
    .A(A), .B(B), .ES(ES),
    .out_nan(out_nan), .out_inf(out_inf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] exp;
    int           acc;
    bit           lat;
    string        name;
  } item_t;

  item_t sb_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_pops   = 0;

  function automatic logic [127:0] pk(logic sa, logic sb, logic as_, logic comp,
                                      logic [27:0] a, logic [27:0] b, logic [7:0] es,
                                      logic nan, logic inf);
    return {58'd0, sa, sb, as_, comp, a, b, es, nan, inf};
  endfunction

  function automatic logic [127:0] actual();
    return pk(SA, SB, A_S, Comp, A, B, ES, out_nan, out_inf);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compare every result the DUT hands over against the scoreboard head
  always @(negedge clk) begin
    item_t it;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", {127'd0, out_valid}, 128'd0);
      end else begin
        it = sb_q.pop_front();
        n_pops++;
        check(it.name, actual(), it.exp);
        if (it.lat) check({it.name, "_latency"}, 128'(cyc - it.acc), 128'd2);
      end
    end
  end

  // Present one operand pair and hold it until it is accepted (bounded wait)
  task automatic send(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic as_, input logic [127:0] exp, input bit lat);
    int budget = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_as = as_;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready) check({name, "_accept_timeout"}, {127'd0, in_ready}, 128'd1);
    else sb_q.push_back('{exp, cyc, lat, name});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget = 0;
    while (sb_q.size() != 0 && budget < 50) begin
      budget++;
      @(posedge clk);
    end
    #2;
    check({name, "_drained"}, 128'(sb_q.size()), 128'd0);
  endtask

  localparam logic [127:0] E_T1 = pk(0, 0, 0, 1, 28'h8000000, 28'h8000000, 8'h7F, 0, 0);
  localparam logic [127:0] E_T2 = pk(0, 0, 0, 1, 28'h8000000, 28'h4000000, 8'h7F, 0, 0);
  localparam logic [127:0] E_T3 = pk(0, 0, 0, 0, 28'h4000000, 28'h8000000, 8'h7F, 0, 0);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_as = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("reset_outputs", {127'd0, out_valid} | actual(), 128'd0);
    check("reset_in_ready", {127'd0, in_ready}, 128'd1);
    rst = 1'b0;

    // Directed vectors, issued back to back with the output always ready
    send("t1_equal",       32'h3F800000, 32'h3F800000, 1'b0, E_T1, 1'b1);
    send("t2_b_smaller",   32'h3F800000, 32'h3F000000, 1'b0, E_T2, 1'b1);
    send("t3_a_smaller",   32'h3F000000, 32'h3F800000, 1'b0, E_T3, 1'b1);
    send("t4_d30_sticky",  32'h3F800000, 32'h30800000, 1'b0,
         pk(0, 0, 0, 1, 28'h8000000, 28'h0000001, 8'h7F, 0, 0), 1'b1);
    send("t4_b_zero",      32'h3F800000, 32'h00000000, 1'b0,
         pk(0, 0, 0, 1, 28'h8000000, 28'h0000000, 8'h7F, 0, 0), 1'b1);
    send("d7_sticky",      32'h3F800000, 32'h3C000001, 1'b0,
         pk(0, 0, 0, 1, 28'h8000000, 28'h0100001, 8'h7F, 0, 0), 1'b1);
    send("signs_sub",      32'hBF800000, 32'h3F000000, 1'b1,
         pk(1, 0, 1, 1, 28'h8000000, 28'h4000000, 8'h7F, 0, 0), 1'b1);
    send("denormals",      32'h00400000, 32'h00800000, 1'b0,
         pk(0, 0, 0, 0, 28'h4000000, 28'h8000000, 8'h01, 0, 0), 1'b1);
    send("both_zero",      32'h00000000, 32'h00000000, 1'b0,
         pk(0, 0, 0, 1, 28'h0000000, 28'h0000000, 8'h01, 0, 0), 1'b1);
    send("inf_plus_one",   32'h7F800000, 32'h3F800000, 1'b0,
         pk(0, 0, 0, 1, 28'h8000000, 28'h0000001, 8'hFF, 0, 1), 1'b1);
    send("nan_b",          32'h3F800000, 32'h7FC00000, 1'b0,
         pk(0, 0, 0, 0, 28'h0000001, 28'hC000000, 8'hFF, 1, 0), 1'b1);
    send("inf_minus_inf",  32'h7F800000, 32'h7F800000, 1'b1,
         pk(0, 0, 1, 1, 28'h8000000, 28'h8000000, 8'hFF, 1, 0), 1'b1);
    drain("directed");

    // Backpressure: three pairs against a five-cycle stall
    out_ready = 1'b0;
    fork
      begin
        send("bp1", 32'h3F800000, 32'h3F800000, 1'b0, E_T1, 1'b0);
        send("bp2", 32'h3F800000, 32'h3F000000, 1'b0, E_T2, 1'b0);
        send("bp3", 32'h3F000000, 32'h3F800000, 1'b0, E_T3, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        repeat (2) begin
          @(negedge clk);
          check("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
          check("bp_out_valid_held", {127'd0, out_valid}, 128'd1);
          check("bp_out_frozen", actual(), E_T1);
        end
        @(posedge clk); #1;
        pops0 = n_pops;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("bp_three_in_three_cycles", 128'(n_pops - pops0), 128'd3);
      end
    join
    drain("backpressure");

    // inf + (-inf) is an effective subtraction, so the result is flagged NaN
    send("t6_inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0,
         pk(0, 1, 0, 1, 28'h8000000, 28'h8000000, 8'hFF, 1, 0), 1'b1);
    drain("t6");

    // Reset while two pairs are in flight drops both of them
    out_ready = 1'b0;
    send("drop1", 32'h3F800000, 32'h3F800000, 1'b0, E_T1, 1'b0);
    send("drop2", 32'h3F800000, 32'h3F000000, 1'b0, E_T2, 1'b0);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("rst_drop_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_drop_outputs", actual(), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("rst_nothing_emerges", {127'd0, out_valid}, 128'd0);

    send("post_reset", 32'h3F800000, 32'h3F800000, 1'b0, E_T1, 1'b1);
    drain("post_reset");

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
